// File: rtl/uart_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared definitions for the UART readback transmit path: frame field
// widths, bit timing and the transmit FSM state encoding.
// ---------------------------------------------------------------------------
package uart_transmitter_pkg;

  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 4;
  localparam int BYTE_W        = ADDR_W + DATA_W;
  localparam int FRAME_BITS    = 11;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity bit carried in the frame: even parity over the byte, inverted
  // when odd parity is selected.
  function automatic logic frame_parity(input logic [BYTE_W-1:0] byte_val,
                                        input logic               odd);
    return (^byte_val) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Synchronous FIFO holding {address,data} bytes waiting to be framed.
// Ports:
//   clk, rst        - system clock, synchronous active-low reset
//   push, push_data - write request and byte (ignored while full)
//   pop             - read request (ignored while empty)
//   pop_data        - byte at the head of the FIFO (valid while !empty)
//   full, empty     - occupancy flags
// ---------------------------------------------------------------------------
module tx_fifo
  import uart_transmitter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Serialises {address,data} readback pairs as 11-bit UART frames
// (start, 8 data bits LSB first, parity, stop) paced by a 16x baud tick.
// Ports:
//   clk, rst   - system clock, synchronous active-low reset
//   tick_16bd  - one-cycle enable at 16x baud
//   valid      - request; address/data held stable while high
//   address    - frame bits [7:4]
//   data       - frame bits [3:0]
//   ack        - one-cycle pulse when the pair enters the FIFO
//   Tx         - serial line, idle high
//   busy       - frame on the line or FIFO non-empty
//   full       - FIFO full
// ---------------------------------------------------------------------------
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_16bd,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              Tx,
  output logic              busy,
  output logic              full
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'd7;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [3:0]        tick_cnt;
  logic [3:0]        tick_cnt_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_next;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] shift_next;
  logic              parity_bit;
  logic              parity_next;
  logic              tx_next;
  logic              busy_next;
  logic              bit_done;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_data;

  // Blocking on the previous ack makes a held valid accepted every other
  // cycle, giving the requester a cycle to drop it.
  assign push = valid && !full && !ack;

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({address, data}),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (full),
    .empty    (fifo_empty)
  );

  assign bit_done = tick_16bd && (tick_cnt == TICK_LAST);

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    parity_next   = parity_bit;
    pop           = 1'b0;

    if (state != IDLE && tick_16bd) tick_cnt_next = tick_cnt + 4'd1;

    case (state)
      IDLE: begin
        if (tick_16bd && !fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_data;
          parity_next   = frame_parity(fifo_data, PARITY_ODD);
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_next   = shift >> 1;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) state_next = PARITY;
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Tx is registered from the next-state view so the line changes in the
    // cycle right after the tick that moves the FSM.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE) || !fifo_empty || push;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      Tx         <= 1'b1;
      busy       <= 1'b0;
      ack        <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      Tx         <= tx_next;
      busy       <= busy_next;
      ack        <= push;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Scoreboarded bench: accepted pairs are queued, a line monitor decodes every
// frame from Tx and compares it with a frame built from the byte's bits.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;
  import uart_transmitter_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam bit PARITY_ODD = 1'b0;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       tick_16bd = 1'b0;
  logic       valid     = 1'b0;
  logic [3:0] address   = '0;
  logic [3:0] data      = '0;
  logic       ack;
  logic       Tx;
  logic       busy;
  logic       full;

  uart_transmitter #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_16bd(tick_16bd),
    .valid    (valid),
    .address  (address),
    .data     (data),
    .ack      (ack),
    .Tx       (Tx),
    .busy     (busy),
    .full     (full)
  );

  always #5 clk = ~clk;

  int         checks      = 0;
  int         errors      = 0;
  int         tick_period = 4;
  int         tick_phase  = 0;
  logic [7:0] sb_q[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame: line level of each bit slot, slot 0 first on the wire.
  function automatic logic [10:0] modelFrame(input logic [7:0] b);
    logic [10:0] f;
    int          ones;
    int          bv;
    ones = 0;
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bv       = (int'(b) / (1 << i)) % 2;
      f[i + 1] = (bv == 1);
      ones     = ones + bv;
    end
    f[9]  = ((ones % 2) == 1) ^ PARITY_ODD;
    f[10] = 1'b1;
    return f;
  endfunction

  // Tick generator: one cycle high every tick_period cycles (always high at 1).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_phase++;
      if (tick_phase >= tick_period) tick_phase = 0;
      tick_16bd = (tick_phase == 0);
    end
  end

  // Line monitor: samples each bit slot mid-bit and scores complete frames.
  bit          in_frame   = 0;
  bit          expect_b2b = 0;
  int          since_fall = 0;
  logic [10:0] seen       = '0;
  logic [10:0] last_frame = '0;

  always @(negedge clk) begin
    int k;
    if (!rst) begin
      in_frame   = 0;
      expect_b2b = 0;
    end else begin
      since_fall++;
      if (!in_frame) begin
        if (Tx == 1'b0) begin
          if (expect_b2b) checkOutput("frame_spacing", since_fall, 177 * tick_period);
          expect_b2b = 0;
          in_frame   = 1;
          since_fall = 0;
          seen       = '0;
        end
      end else if (since_fall >= 8 * tick_period &&
                   ((since_fall - 8 * tick_period) % (16 * tick_period)) == 0) begin
        k       = (since_fall - 8 * tick_period) / (16 * tick_period);
        seen[k] = Tx;
        if (k == 10) begin
          in_frame   = 0;
          last_frame = seen;
          checkOutput("frame_expected", (sb_q.size() != 0) ? 1 : 0, 1);
          if (sb_q.size() != 0) checkOutput("frame_bits", seen, modelFrame(sb_q.pop_front()));
          expect_b2b = (sb_q.size() != 0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d,
                               input int budget, output bit accepted);
    address  = a;
    data     = d;
    valid    = 1'b1;
    accepted = 0;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(posedge clk);
      #1;
      if (ack) accepted = 1;
    end
    if (accepted) sb_q.push_back({a, d});
    valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitTxLow(input int budget, output bit seen_low);
    seen_low = 0;
    for (int i = 0; i < budget && !seen_low; i++) begin
      @(posedge clk);
      #1;
      if (Tx == 1'b0) seen_low = 1;
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy || in_frame) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, (n < budget) ? 1 : 0, 1);
  endtask

  initial begin
    bit acc;
    bit low;
    int bad;

    // Reset state
    rst = 1'b0;
    waitCycles(3);
    checkOutput("reset_Tx", Tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_full", full, 0);
    rst = 1'b1;

    // Idle with ticks running
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      waitCycles(1);
      if (Tx !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 || full !== 1'b0) bad++;
    end
    checkOutput("idle_bad_cycles", bad, 0);

    // Directed 0x3A, even parity
    applyStimulus(4'h3, 4'hA, 100, acc);
    checkOutput("ack_3A", acc, 1);
    waitCycles(1);
    checkOutput("ack_single_pulse", ack, 0);
    waitDrain("drain_3A", 3000);
    checkOutput("frame_3A_literal", last_frame, 11'h474);

    // Randomised pairs with random spacing
    for (int n = 0; n < 10; n++) begin
      waitCycles($urandom_range(0, 300));
      applyStimulus(4'($urandom), 4'($urandom), 5000, acc);
      checkOutput("ack_random", acc, 1);
    end
    waitDrain("drain_random", 20000);

    // Fill the FIFO behind a frame already on the line
    applyStimulus(4'h1, 4'h2, 100, acc);
    checkOutput("ack_fill_first", acc, 1);
    waitTxLow(200, low);
    checkOutput("fill_first_started", low, 1);
    for (int n = 0; n < FIFO_DEPTH; n++) begin
      applyStimulus(4'(n + 4), 4'(15 - n), 4, acc);
      checkOutput("ack_fill", acc, 1);
    end
    checkOutput("full_after_fill", full, 1);
    applyStimulus(4'h9, 4'h6, 100, acc);
    checkOutput("no_ack_when_full", acc, 0);
    applyStimulus(4'h9, 4'h6, 2000, acc);
    checkOutput("ack_after_pop", acc, 1);
    waitDrain("drain_fill", 8000);

    // Reset mid-DATA abandons the frame and the queued entry
    applyStimulus(4'hC, 4'h5, 100, acc);
    checkOutput("ack_rst_a", acc, 1);
    applyStimulus(4'h7, 4'hE, 100, acc);
    checkOutput("ack_rst_b", acc, 1);
    waitTxLow(200, low);
    checkOutput("rst_frame_started", low, 1);
    waitCycles(16 * tick_period * 3);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("midframe_rst_Tx", Tx, 1);
    checkOutput("midframe_rst_busy", busy, 0);
    checkOutput("midframe_rst_full", full, 0);
    rst = 1'b1;
    sb_q.delete();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      waitCycles(1);
      if (Tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("no_frame_after_rst", bad, 0);

    // Tick held high: two frames back to back
    tick_period = 1;
    waitCycles(2);
    applyStimulus(4'hA, 4'h5, 100, acc);
    checkOutput("ack_tick_high_a", acc, 1);
    applyStimulus(4'h0, 4'hF, 100, acc);
    checkOutput("ack_tick_high_b", acc, 1);
    waitDrain("drain_tick_high", 1000);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmit path returning register readback to the host over `Tx`, the reverse direction of the receive chain. It accepts 4-bit address/data pairs from the register blocks through a valid/ack handshake and buffers them in a small FIFO. Each entry is serialised as an 11-bit frame (start, 8 data bits LSB first, parity, stop), paced by a 16x-baud tick. It sits beside the clock handler and the address decoder, fed by the OR-ed readback bus.

## Interface
- `FIFO_DEPTH`, 4: entries buffered; power of two, 2..16.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low.
- `tick_16bd` input 1: one-cycle enable at 16x baud rate.
- `valid` input 1: request, `address`/`data` stable while high.
- `address` input 4: register address, sent as frame bits [7:4].
- `data` input 4: register value, sent as frame bits [3:0].
- `ack` output 1: one-cycle pulse, entry accepted into FIFO.
- `Tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is on the line or FIFO non-empty.
- `full` output 1: FIFO full.

## Operation
- Reset (`rst`=0 at a `clk` edge) drives `Tx`=1, `ack`=0, `busy`=0, `full`=0, clears the FIFO and returns the FSM to IDLE. This applies mid-frame too: the partial frame is abandoned and the line returns high the next cycle.
- Push: `valid`=1, `full`=0 and `ack` not asserted in the previous cycle causes `{address,data}` to be written and `ack` to pulse for one cycle.
  - The requester drops `valid` after `ack`. A held `valid` is re-accepted every other cycle.
  - With `full`=1 there is no `ack`, and the request waits.
  - `full` is evaluated before a same-cycle pop, so a push is refused in the cycle the FIFO pops while full.
- Parity bit: XOR of the 8 data bits, XOR `PARITY_ODD`.
- FSM states:
  - IDLE: `Tx`=1. On `tick_16bd` with FIFO non-empty, pop the head into an 8-bit shift register, compute parity and go to START.
  - START: `Tx`=0 for 16 ticks, then DATA.
  - DATA: `Tx`=shift[0], shifted right every 16 ticks; 8 bits, then PARITY.
  - PARITY: parity bit for 16 ticks, then STOP.
  - STOP: `Tx`=1 for 16 ticks, then IDLE.
- Counters: tick counter 4 bits, wraps 15→0 to advance a bit. Bit counter 3 bits, for DATA only.
- FIFO pointers are log2(`FIFO_DEPTH`) bits plus one wrap bit.
  - `full`: pointers equal except for the wrap bit.
  - empty: pointers equal.

## Timing
- All outputs are registered.
- `ack` asserts in the cycle after the accepting edge.
- Frame start: the first `tick_16bd` at or after the FIFO becoming non-empty moves IDLE→START. `Tx` falls on the following cycle.
- Frame length: exactly 11×16 = 176 ticks, start-bit fall to end of stop bit.
- Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next start bit begins one tick after the stop bit completes. The gap is no more than 1 tick beyond a nominal stop bit.
- `busy` falls in the cycle after STOP ends with the FIFO empty.
- `tick_16bd` held high continuously is legal; frame length is then 176 `clk` cycles.
- A push and a pop in the same cycle both take effect, so the count is unchanged.

## Structure
- Shared package holds:
  - frame field widths: `ADDR_W`=4, `DATA_W`=4, `FRAME_BITS`=11;
  - `TICKS_PER_BIT`=16;
  - the FSM state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
- One sub-module, `tx_fifo`: synchronous FIFO, 8-bit wide, depth `FIFO_DEPTH`, with push/pop/full/empty.
- The FSM, counters and shift register stay in `uart_transmitter`.

## Test plan
- Reset then idle, `tick_16bd` running: `Tx`=1, `busy`=0, `ack`=0, `full`=0 for 500 cycles.
- Push address 0x3 / data 0xA, even parity, `tick_16bd` every 4 `clk`: one `ack`, then `Tx` = 0, 0,1,0,1,1,1,0,0, 0, 1, each bit 64 cycles. Byte 0x3A is sent LSB first with parity 0.
- Same push with `PARITY_ODD`=1 and data 0xB (byte 0x3B, five ones): parity bit=0.
- Hold `valid` with five distinct entries while `Tx` is busy, `FIFO_DEPTH`=4:
  - four `ack`s, then `full`=1 and no fifth `ack`;
  - the fifth entry is accepted after the first pop;
  - all five frames come out in order with no extra gaps.
- Assert `rst`=0 for one cycle mid-DATA of a frame: `Tx`=1 next cycle, FIFO empty, `busy`=0, and no further frames.
- `tick_16bd` tied high, two entries queued: second start bit follows the first stop bit within 1 cycle, and total `Tx` activity is 352 cycles.
